// File: rtl/tpu_job_arbiter.sv
// rtl/tpu_job_arbiter.sv - round-robin, credit-limited job arbiter in front of a shared TPU core
module tpu_job_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 16,
  parameter int TPU_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_a,
  input  logic [NREQ*DW-1:0]       req_b,
  input  logic [NREQ*3-1:0]        req_fn,
  output logic [NREQ-1:0]          gnt,
  output logic [DW-1:0]            tpu_a,
  output logic [DW-1:0]            tpu_b,
  input  logic [DW-1:0]            tpu_relu,
  input  logic [DW-1:0]            tpu_tanh,
  input  logic [DW-1:0]            tpu_sigmoid,
  input  logic [DW-1:0]            tpu_softmax,
  input  logic [DW-1:0]            tpu_bn,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NST  = TPU_LAT + 1;
  localparam int LAST = NST - 1;

  // Job credits, round-robin pointer and operand registers
  logic [CW-1:0]  credits_q, credits_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  tpu_a_q, tpu_a_d, tpu_b_q, tpu_b_d;

  // Tag pipe: one stage per edge between acceptance and capture
  logic           tag_v_q  [NST];
  logic [IDW-1:0] tag_id_q [NST];
  logic [2:0]     tag_fn_q [NST];

  // Response FIFO storage; pointers carry one wrap bit
  logic [DW-1:0]  mem_data_q [FIFO_DEPTH];
  logic [IDW-1:0] mem_id_q   [FIFO_DEPTH];
  logic           mem_err_q  [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic           accept;
  logic           pop;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic [DW-1:0]  sel_a, sel_b;
  logic [2:0]     sel_fn;
  logic           cap_en;
  logic [DW-1:0]  cap_data;
  logic           cap_err;

  // Round-robin search starting just after the last winner; no grant without a credit
  always_comb begin
    gnt     = '0;
    accept  = 1'b0;
    win_idx = ptr_q;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!accept && (credits_q != '0) && req[cand]) begin
        accept  = 1'b1;
        win_idx = cand;
      end
    end
    if (accept) gnt[win_idx] = 1'b1;
  end

  // Operand and activation-select mux for the granted requester
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_fn = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*DW +: DW];
        sel_b  = req_b[i*DW +: DW];
        sel_fn = req_fn[i*3 +: 3];
      end
    end
  end

  // Capture side: the tag leaving the pipe picks the matching TPU output; fn 5..7 report an error
  always_comb begin
    cap_en   = tag_v_q[LAST];
    cap_err  = 1'b0;
    cap_data = '0;
    case (tag_fn_q[LAST])
      3'd0:    cap_data = tpu_relu;
      3'd1:    cap_data = tpu_tanh;
      3'd2:    cap_data = tpu_sigmoid;
      3'd3:    cap_data = tpu_softmax;
      3'd4:    cap_data = tpu_bn;
      default: cap_err  = 1'b1;
    endcase
  end

  assign rsp_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = rsp_valid & rsp_ready;

  // Next-state for pointers, operands and credits; a pop never frees a credit in the same cycle
  always_comb begin
    ptr_d     = accept ? win_idx : ptr_q;
    tpu_a_d   = accept ? sel_a : tpu_a_q;
    tpu_b_d   = accept ? sel_b : tpu_b_q;
    wr_ptr_d  = cap_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    credits_d = credits_q;
    if (accept && !pop) credits_d = credits_q - CW'(1);
    else if (!accept && pop) credits_d = credits_q + CW'(1);
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CW'(FIFO_DEPTH);
      ptr_q     <= IDW'(NREQ - 1);
      tpu_a_q   <= '0;
      tpu_b_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      ptr_q     <= ptr_d;
      tpu_a_q   <= tpu_a_d;
      tpu_b_q   <= tpu_b_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Tag shift register tracking each job through the fixed TPU latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NST; s++) begin
        tag_v_q[s]  <= 1'b0;
        tag_id_q[s] <= '0;
        tag_fn_q[s] <= '0;
      end
    end else begin
      tag_v_q[0]  <= accept;
      tag_id_q[0] <= win_idx;
      tag_fn_q[0] <= sel_fn;
      for (int s = 1; s < NST; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
        tag_fn_q[s] <= tag_fn_q[s-1];
      end
    end
  end

  // FIFO write; credits guarantee a free slot, so there is no full check
  always_ff @(posedge clk) begin
    if (cap_en) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= cap_data;
      mem_id_q[wr_ptr_q[AW-1:0]]   <= tag_id_q[LAST];
      mem_err_q[wr_ptr_q[AW-1:0]]  <= cap_err;
    end
  end

  assign rsp_data = rsp_valid ? mem_data_q[rd_ptr_q[AW-1:0]] : '0;
  assign rsp_id   = rsp_valid ? mem_id_q[rd_ptr_q[AW-1:0]]   : '0;
  assign rsp_err  = rsp_valid ? mem_err_q[rd_ptr_q[AW-1:0]]  : 1'b0;
  assign busy     = (credits_q != CW'(FIFO_DEPTH));
  assign tpu_a    = tpu_a_q;
  assign tpu_b    = tpu_b_q;

endmodule

// File: tb/tb_tpu_job_arbiter.sv
// tb/tb_tpu_job_arbiter.sv - directed self-checking bench for tpu_job_arbiter
module tb_tpu_job_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*DW-1:0]  req_a = '0;
  logic [NREQ*DW-1:0]  req_b = '0;
  logic [NREQ*3-1:0]   req_fn = '0;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       tpu_a, tpu_b;
  logic [DW-1:0]       tpu_relu = '0, tpu_tanh = '0, tpu_sigmoid = '0, tpu_softmax = '0, tpu_bn = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [DW-1:0]       rsp_data;
  logic [1:0]          rsp_id;
  logic                rsp_err;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_id[$];
  int exp_data[$];
  int exp_err[$];

  tpu_job_arbiter #(.NREQ(NREQ), .DW(DW), .TPU_LAT(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b), .req_fn(req_fn),
    .gnt(gnt), .tpu_a(tpu_a), .tpu_b(tpu_b),
    .tpu_relu(tpu_relu), .tpu_tanh(tpu_tanh), .tpu_sigmoid(tpu_sigmoid),
    .tpu_softmax(tpu_softmax), .tpu_bn(tpu_bn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] act(input int fn, input logic [DW-1:0] m);
    case (fn)
      0:       act = ($signed(m) > 0) ? m : '0;
      1:       act = m + 16'd1;
      2:       act = m ^ 16'h00ff;
      3:       act = m >> 1;
      4:       act = m - 16'd3;
      default: act = '0;
    endcase
  endfunction

  // TPU core model: product registered one edge after the operands, activations one edge later
  logic [DW-1:0] m1 = '0;
  always @(posedge clk) begin
    m1          <= tpu_a * tpu_b;
    tpu_relu    <= act(0, m1);
    tpu_tanh    <= act(1, m1);
    tpu_sigmoid <= act(2, m1);
    tpu_softmax <= act(3, m1);
    tpu_bn      <= act(4, m1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    rsp_ready = 1'b0;
    reset_n   = 1'b0;
    cyc();
    cyc();
    reset_n   = 1'b1;
  endtask

  task automatic sample_rsp();
    if (rsp_valid) begin
      if (exp_id.size() == 0) chk("rsp_extra", 1, 0);
      else begin
        chk("rsp_id", 32'(rsp_id), exp_id.pop_front());
        chk("rsp_data", 32'(rsp_data), exp_data.pop_front());
        chk("rsp_err", 32'(rsp_err), exp_err.pop_front());
      end
    end
  endtask

  initial begin
    int ngr;
    int acc;
    int nv;

    // Reset state
    reset_n = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_tpu_a", 32'(tpu_a), 0);
    chk("rst_tpu_b", 32'(tpu_b), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single job: 3*4 relu, result three edges after acceptance
    do_reset();
    req = 4'b0001; req_a[15:0] = 16'd3; req_b[15:0] = 16'd4; req_fn[2:0] = 3'd0;
    #1 chk("sj_gnt", 32'(gnt), 32'h1);
    cyc();
    req = '0;
    #1;
    chk("sj_tpu_a", 32'(tpu_a), 3);
    chk("sj_tpu_b", 32'(tpu_b), 4);
    chk("sj_v0", 32'(rsp_valid), 0);
    chk("sj_busy", 32'(busy), 1);
    cyc(); #1 chk("sj_v1", 32'(rsp_valid), 0);
    cyc(); #1 chk("sj_v2", 32'(rsp_valid), 0);
    cyc(); #1;
    chk("sj_v3", 32'(rsp_valid), 1);
    chk("sj_data", 32'(rsp_data), 12);
    chk("sj_id", 32'(rsp_id), 0);
    chk("sj_err", 32'(rsp_err), 0);
    cyc(); #1;
    chk("sj_hold_v", 32'(rsp_valid), 1);
    chk("sj_hold_d", 32'(rsp_data), 12);
    rsp_ready = 1'b1;
    cyc(); #1;
    chk("sj_pop_v", 32'(rsp_valid), 0);
    chk("sj_pop_busy", 32'(busy), 0);

    // Round-robin with all requesters active; responses in acceptance order
    do_reset();
    rsp_ready = 1'b1;
    req = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW]  = 16'(i + 1);
      req_b[i*DW +: DW]  = 16'd2;
      req_fn[i*3 +: 3]   = 3'd0;
    end
    ngr = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ngr < 8) begin
        chk("rr_gnt", 32'(gnt), 32'(1 << (ngr % 4)));
        exp_id.push_back(ngr % 4);
        exp_data.push_back(((ngr % 4) + 1) * 2);
        exp_err.push_back(0);
        ngr++;
      end
      sample_rsp();
      cyc();
      if (ngr == 8) req = '0;
    end
    chk("rr_left", 32'(exp_id.size()), 0);
    chk("rr_busy", 32'(busy), 0);

    // Back-pressure: eight credits, then refill one by one
    do_reset();
    req = 4'b0100; req_a[47:32] = 16'd1; req_b[47:32] = 16'd1; req_fn[8:6] = 3'd0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (gnt == 4'b0100) acc++;
      cyc();
    end
    chk("bp_accepts", 32'(acc), 8);
    #1 chk("bp_full_gnt", 32'(gnt), 0);
    rsp_ready = 1'b1;
    #1 chk("bp_pop_blk", 32'(gnt), 0);
    cyc();
    rsp_ready = 1'b0;
    #1 chk("bp_refill", 32'(gnt), 32'h4);
    cyc();
    #1 chk("bp_full2", 32'(gnt), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1; req = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!busy) break;
      cyc();
    end
    chk("bp_drained", 32'(busy), 0);

    // Illegal activation select
    do_reset();
    req = 4'b0010; req_a[31:16] = 16'd7; req_b[31:16] = 16'd7; req_fn[5:3] = 3'd6;
    #1 chk("il_gnt", 32'(gnt), 32'h2);
    cyc();
    req = '0;
    #1 chk("il_busy", 32'(busy), 1);
    cyc(); cyc(); cyc();
    #1;
    chk("il_valid", 32'(rsp_valid), 1);
    chk("il_err", 32'(rsp_err), 1);
    chk("il_data", 32'(rsp_data), 0);
    chk("il_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    cyc();
    #1 chk("il_credit_back", 32'(busy), 0);

    // Function select on one requester: 10*5 through each activation
    do_reset();
    rsp_ready = 1'b1;
    req_a[15:0] = 16'd10; req_b[15:0] = 16'd5;
    for (int k = 0; k < 5; k++) begin
      req = 4'b0001;
      req_fn[2:0] = 3'(k);
      #1 chk("fs_gnt", 32'(gnt), 32'h1);
      exp_id.push_back(0);
      exp_data.push_back(int'(act(k, 16'd50)));
      exp_err.push_back(0);
      sample_rsp();
      cyc();
    end
    req = '0;
    for (int c = 0; c < 10; c++) begin
      #1 sample_rsp();
      cyc();
    end
    chk("fs_left", 32'(exp_id.size()), 0);

    // Reset mid-stream: 2 queued, 3 in flight, all discarded
    do_reset();
    req = 4'hF;
    for (int c = 0; c < 5; c++) cyc();
    req = '0;
    chk("mr_pre_valid", 32'(rsp_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    cyc();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid) nv++;
      cyc();
    end
    chk("mr_stale", 32'(nv), 0);
    chk("mr_busy_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
